// File: rtl/pio_deb_pkg.sv
// Shared constants for the debounced Avalon-MM PIO.
// Register map, edge-mode encodings and PWM width.
package pio_deb_pkg;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
  localparam logic [2:0] ADDR_PWM_DUTY = 3'd6;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  localparam int PWM_W = 8;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: 2-FF synchroniser, stability counter
// and debounced output flop.
module pio_debounce_ch
  import pio_deb_pkg::*;
#(
  parameter int   DEB_CYCLES = 50000,
  parameter logic RESET_VAL  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic deb
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Flip only after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= RESET_VAL;
      sync_q2 <= RESET_VAL;
      cnt     <= '0;
      deb     <= RESET_VAL;
    end else begin
      sync_q1 <= pin;
      sync_q2 <= sync_q1;
      if (sync_q2 != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync_q2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pio_deb_avmm.sv
// Avalon-MM PIO: debounced inputs with edge capture/irq, set/clr outputs.
// Optional global PWM dimmer on pin_out when PIO_DEB_PWM_EN is defined.
module pio_deb_avmm
  import pio_deb_pkg::*;
#(
  parameter int                 NUM_IN     = 2,
  parameter int                 NUM_OUT    = 8,
  parameter int                 DEB_CYCLES = 50000,
  parameter int                 EDGE_MODE  = 0,
  parameter logic [NUM_IN-1:0]  IN_RESET   = '1,
  parameter logic [NUM_OUT-1:0] OUT_RESET  = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [NUM_IN-1:0]  pin_in,
  output logic [NUM_OUT-1:0] pin_out,
  output logic               irq
);

  logic [NUM_IN-1:0]  din;
  logic [NUM_IN-1:0]  din_d;
  logic [NUM_IN-1:0]  edge_hit;
  logic [NUM_IN-1:0]  edge_cap;
  logic [NUM_IN-1:0]  cap_clr;
  logic [NUM_IN-1:0]  irq_mask;
  logic [NUM_OUT-1:0] data_out;
  logic [31:0]        rd_mux;
  logic [NUM_IN-1:0]  wd_in;
  logic [NUM_OUT-1:0] wd_out;

  assign wd_in  = writedata[NUM_IN-1:0];
  assign wd_out = writedata[NUM_OUT-1:0];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    pio_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .RESET_VAL  (IN_RESET[i])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (pin_in[i]),
      .deb     (din[i])
    );
  end

  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      EDGE_RISE: edge_hit = din & ~din_d;
      EDGE_BOTH: edge_hit = din ^ din_d;
      default:   edge_hit = din_d & ~din;
    endcase
  end

  assign cap_clr = (write && address == ADDR_EDGE_CAP)
                 ? wd_in : '0;

`ifdef PIO_DEB_PWM_EN
  logic [PWM_W-1:0] pwm_duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_duty <= '1;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (write && address == ADDR_PWM_DUTY)
        pwm_duty <= writedata[PWM_W-1:0];
    end
  end

  // Full duty must never blank, so 255 bypasses the compare.
  assign pwm_on  = (pwm_cnt < pwm_duty) || (&pwm_duty);
  assign pin_out = data_out & {NUM_OUT{pwm_on}};
`else
  assign pin_out = data_out;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA_IN:  rd_mux[NUM_IN-1:0]  = din;
      ADDR_DATA_OUT: rd_mux[NUM_OUT-1:0] = data_out;
      ADDR_IRQ_MASK: rd_mux[NUM_IN-1:0]  = irq_mask;
      ADDR_EDGE_CAP: rd_mux[NUM_IN-1:0]  = edge_cap;
`ifdef PIO_DEB_PWM_EN
      ADDR_PWM_DUTY: rd_mux[PWM_W-1:0]   = pwm_duty;
`endif
      default:       rd_mux = '0;
    endcase
  end

  // A fresh edge outranks a same-cycle W1C on its bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      data_out <= OUT_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      din_d    <= IN_RESET;
    end else begin
      din_d    <= din;
      edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
      irq      <= |(edge_cap & irq_mask);
      if (read)
        readdata <= rd_mux;
      if (write) begin
        case (address)
          ADDR_DATA_OUT: data_out <= wd_out;
          ADDR_OUT_SET:  data_out <= data_out | wd_out;
          ADDR_OUT_CLR:  data_out <= data_out & ~wd_out;
          ADDR_IRQ_MASK: irq_mask <= wd_in;
          default: ;
        endcase
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^writedata;

endmodule

// File: tb/tb_pio_deb_avmm.sv
// Directed bench for pio_deb_avmm, DEB_CYCLES=4, falling-edge capture.
// Covers PWM checks when PIO_DEB_PWM_EN is defined.
module tb_pio_deb_avmm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pin_in;
  logic [7:0]  pin_out;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  int          hi_cnt;
  int          bad_cnt;

  always #5 clk = ~clk;

  pio_deb_avmm #(
    .NUM_IN     (2),
    .NUM_OUT    (8),
    .DEB_CYCLES (4),
    .EDGE_MODE  (0),
    .IN_RESET   (2'b11),
    .OUT_RESET  (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .pin_in    (pin_in),
    .pin_out   (pin_out),
    .irq       (irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a,
                          output logic [31:0] d);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_count(output int hi, output int bad);
    hi  = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pin_out == 8'hFF) hi++;
      else if (pin_out != 8'h00) bad++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = 3'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    pin_in    = 2'b11;
    idle(3);
    reset_n = 1'b1;

    // Reset state
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd0, rd);
    check("rst_data_in", rd, 32'h3);
    bus_read(3'd1, rd);
    check("rst_data_out", rd, 32'h0);
    check("rst_pin_out", {24'b0, pin_out}, 32'h0);
    bus_read(3'd5, rd);
    check("rst_edge_cap", rd, 32'h0);
    bus_read(3'd6, rd);
`ifdef PIO_DEB_PWM_EN
    check("rst_pwm_duty", rd, 32'hFF);
`else
    check("rst_pwm_duty", rd, 32'h0);
`endif

    // 3-cycle glitch must be rejected
    @(negedge clk);
    pin_in[0] = 1'b0;
    idle(3);
    pin_in[0] = 1'b1;
    idle(10);
    bus_read(3'd0, rd);
    check("glitch_data_in", rd, 32'h3);
    bus_read(3'd5, rd);
    check("glitch_edge_cap", rd, 32'h0);

    // Sustained low: debounced flips at k+6
    @(negedge clk);
    pin_in[0] = 1'b0;
    address   = 3'd0;
    read      = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 6) check("deb_before_flip", readdata, 32'h3);
      if (i == 7) check("deb_after_flip", readdata, 32'h2);
    end
    read = 1'b0;
    check("nomask_irq", {31'b0, irq}, 32'h0);
    bus_read(3'd5, rd);
    check("fall_edge_cap", rd, 32'h1);

    // Clear, then a rising edge is not captured
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    check("w1c_edge_cap", rd, 32'h0);
    pin_in[0] = 1'b1;
    idle(10);
    bus_read(3'd0, rd);
    check("rise_data_in", rd, 32'h3);
    bus_read(3'd5, rd);
    check("rise_no_cap", rd, 32'h0);

    // Masked irq timing
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, rd);
    check("irq_mask_rb", rd, 32'h1);
    @(negedge clk);
    pin_in[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 7) check("irq_k7", {31'b0, irq}, 32'h0);
      if (i == 8) check("irq_k8", {31'b0, irq}, 32'h1);
    end
    bus_write(3'd5, 32'h1);
    check("irq_at_w1c", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);

    // W1C on the capture cycle: edge wins
    pin_in[0] = 1'b1;
    idle(10);
    pin_in[0] = 1'b0;
    for (int i = 1; i <= 6; i++) @(negedge clk);
    address   = 3'd5;
    writedata = 32'h1;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    bus_read(3'd5, rd);
    check("w1c_vs_edge", rd, 32'h1);
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h1);

    // Output register and atomic set/clear
    bus_write(3'd1, 32'hA5);
    check("pin_out_a5", {24'b0, pin_out}, 32'hA5);
    bus_write(3'd2, 32'h0F);
    bus_write(3'd3, 32'h81);
    bus_read(3'd1, rd);
    check("data_out_setclr", rd, 32'h2E);
    check("pin_out_setclr", {24'b0, pin_out}, 32'h2E);
    bus_read(3'd2, rd);
    check("wo_set_reads0", rd, 32'h0);
    idle(3);
    check("readdata_hold", readdata, 32'h0);
    bus_write(3'd0, 32'h0);
    bus_read(3'd0, rd);
    check("ro_write_ignored", rd, 32'h2);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, rd);
    check("reserved_reads0", rd, 32'h0);

    // Dimmer
    bus_write(3'd1, 32'hFF);
    bus_write(3'd6, 32'd64);
    bus_read(3'd6, rd);
`ifdef PIO_DEB_PWM_EN
    check("pwm_duty_rb", rd, 32'd64);
    pwm_count(hi_cnt, bad_cnt);
    check("pwm64_hi", hi_cnt, 32'd64);
    check("pwm64_bad", bad_cnt, 32'd0);
    bus_write(3'd6, 32'd0);
    pwm_count(hi_cnt, bad_cnt);
    check("pwm0_hi", hi_cnt, 32'd0);
    bus_write(3'd6, 32'd255);
    pwm_count(hi_cnt, bad_cnt);
    check("pwm255_hi", hi_cnt, 32'd256);
`else
    check("pwm_duty_off", rd, 32'h0);
    pwm_count(hi_cnt, bad_cnt);
    check("nopwm_hi", hi_cnt, 32'd256);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
